// File: rtl/sum_accumulator.sv
// sum_accumulator - reduces LEN signed sum beats (or fewer on flush) into one wide total
// Two-state FSM: ACCUM takes beats, DONE holds the result until the consumer accepts it.
module sum_accumulator #(
  parameter int DATAW = 32,
  parameter int ACCW  = 48,
  parameter int LEN   = 16,
  localparam int CNTW = $clog2(LEN + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [DATAW-1:0] sum_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             flush_i,
  output logic [ACCW-1:0]  acc_o,
  output logic [CNTW-1:0]  count_o,
  output logic             ovf_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  typedef enum logic {ACCUM, DONE} state_t;

  state_t                  state, next_state;
  logic signed [ACCW-1:0]  acc;
  logic signed [ACCW-1:0]  sum_ext;
  logic signed [ACCW-1:0]  acc_sum;
  logic [CNTW-1:0]         cnt;
  logic [CNTW-1:0]         cnt_inc;
  logic                    ovf;
  logic                    add_ovf;
  logic                    in_beat;
  logic                    out_beat;
  logic                    close;

  always_comb begin
    sum_ext  = ACCW'($signed(sum_i));
    acc_sum  = acc + sum_ext;
    add_ovf  = (acc[ACCW-1] == sum_ext[ACCW-1]) && (acc_sum[ACCW-1] != acc[ACCW-1]);
    cnt_inc  = cnt + CNTW'(1);
    in_beat  = in_valid_i & in_ready_o;
    out_beat = out_valid_o & out_ready_i;
    // A full count closes regardless of flush; a lone flush only closes a non-empty reduction.
    if (in_beat)
      close = (cnt_inc == CNTW'(LEN)) || flush_i;
    else
      close = flush_i && (cnt != '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      state <= ACCUM;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ACCUM:   if (close) next_state = DONE;
      DONE:    if (out_ready_i) next_state = ACCUM;
      default: next_state = ACCUM;
    endcase
  end

  // in_ready depends only on state and reset, never on out_ready_i.
  always_comb begin
    in_ready_o  = (state == ACCUM) && !rst_i;
    out_valid_o = (state == DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (out_beat) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (in_beat) begin
      acc <= acc_sum;
      cnt <= cnt_inc;
      ovf <= ovf | add_ovf;
    end
  end

  assign acc_o   = acc;
  assign count_o = cnt;
  assign ovf_o   = ovf;

endmodule

// File: tb/tb_sum_accumulator.sv
// tb/tb_sum_accumulator.sv - random and directed checks of sum_accumulator against a reduction model
// Two instances share stimulus: 32b->48b and an 8b->8b one where wrap and overflow are easy to hit.
module tb_sum_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        flush;
  logic        out_ready;
  logic [31:0] sum_a;
  logic [7:0]  sum_b;

  logic        rdy_a, vld_a, ovf_a;
  logic [47:0] acc_a;
  logic [2:0]  cnt_a;
  logic        rdy_b, vld_b, ovf_b;
  logic [7:0]  acc_b;
  logic [2:0]  cnt_b;

  int checks = 0;
  int errors = 0;

  // Reference: one entry per instance, index 0 = 48-bit, 1 = 8-bit.
  bit     m_done [2];
  longint m_acc  [2];
  int     m_cnt  [2];
  bit     m_ovf  [2];
  int     m_w    [2];
  bit     started = 1'b0;

  always #5 clk = ~clk;
  assign sum_b = sum_a[7:0];

  sum_accumulator #(.DATAW(32), .ACCW(48), .LEN(4)) dut_a (
    .clk_i(clk), .rst_i(rst), .sum_i(sum_a), .in_valid_i(in_valid), .in_ready_o(rdy_a),
    .flush_i(flush), .acc_o(acc_a), .count_o(cnt_a), .ovf_o(ovf_a),
    .out_valid_o(vld_a), .out_ready_i(out_ready)
  );

  sum_accumulator #(.DATAW(8), .ACCW(8), .LEN(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .sum_i(sum_b), .in_valid_i(in_valid), .in_ready_o(rdy_b),
    .flush_i(flush), .acc_o(acc_b), .count_o(cnt_b), .ovf_o(ovf_b),
    .out_valid_o(vld_b), .out_ready_i(out_ready)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint wrap(input longint s, input int w);
    longint m, v;
    m = longint'(1) << w;
    v = s & (m - 1);
    if (v >= m / 2) v = v - m;
    return v;
  endfunction

  task automatic compare_one(input int k, input logic rdy, input logic vld,
                             input longint acc, input int cnt, input logic ovf);
    check($sformatf("in_ready[%0d]", k), longint'(rdy), longint'(!m_done[k] && !rst));
    check($sformatf("out_valid[%0d]", k), longint'(vld), longint'(m_done[k]));
    if (m_done[k] || m_cnt[k] == 0) begin
      check($sformatf("acc[%0d]", k), acc, m_acc[k]);
      check($sformatf("count[%0d]", k), longint'(cnt), longint'(m_cnt[k]));
      check($sformatf("ovf[%0d]", k), longint'(ovf), longint'(m_ovf[k]));
    end
  endtask

  task automatic model_update(input int k, input longint x);
    longint s, lo, hi;
    if (rst) begin
      m_done[k] = 1'b0; m_acc[k] = 0; m_cnt[k] = 0; m_ovf[k] = 1'b0;
    end else if (!m_done[k]) begin
      if (in_valid) begin
        s  = m_acc[k] + x;
        lo = -(longint'(1) << (m_w[k] - 1));
        hi = (longint'(1) << (m_w[k] - 1)) - 1;
        if (s < lo || s > hi) m_ovf[k] = 1'b1;
        m_acc[k] = wrap(s, m_w[k]);
        m_cnt[k]++;
        if (m_cnt[k] == 4 || flush) m_done[k] = 1'b1;
      end else if (flush && m_cnt[k] > 0) begin
        m_done[k] = 1'b1;
      end
    end else if (out_ready) begin
      m_done[k] = 1'b0; m_acc[k] = 0; m_cnt[k] = 0; m_ovf[k] = 1'b0;
    end
  endtask

  // One clock: check outputs settled from the last edge, drive new inputs, advance the model.
  task automatic step(input bit v, input logic [31:0] d, input bit f, input bit r, input bit rs);
    logic [31:0] dv;
    @(negedge clk);
    if (started) begin
      compare_one(0, rdy_a, vld_a, longint'($signed(acc_a)), int'(cnt_a), ovf_a);
      compare_one(1, rdy_b, vld_b, longint'($signed(acc_b)), int'(cnt_b), ovf_b);
    end
    in_valid = v; sum_a = d; flush = f; out_ready = r; rst = rs;
    dv = d;
    @(posedge clk);
    model_update(0, longint'($signed(dv)));
    model_update(1, longint'($signed(dv[7:0])));
    started = 1'b1;
  endtask

  task automatic expect_result(input string tag, input longint acc_exp_a, input int cnt_exp,
                               input longint acc_exp_b, input bit ovf_exp_b);
    #1;
    check({tag, "_valid"}, longint'(vld_a), 1);
    check({tag, "_acc_a"}, longint'($signed(acc_a)), acc_exp_a);
    check({tag, "_cnt_a"}, longint'(cnt_a), longint'(cnt_exp));
    check({tag, "_acc_b"}, longint'($signed(acc_b)), acc_exp_b);
    check({tag, "_ovf_b"}, longint'(ovf_b), longint'(ovf_exp_b));
  endtask

  initial begin
    m_w[0] = 48; m_w[1] = 8;
    for (int k = 0; k < 2; k++) begin
      m_done[k] = 1'b0; m_acc[k] = 0; m_cnt[k] = 0; m_ovf[k] = 1'b0;
    end
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; sum_a = '0;

    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    #1;
    check("reset_acc", longint'(acc_a), 0);
    check("reset_valid", longint'(vld_a), 0);

    step(1, 1, 0, 1, 0); step(1, 2, 0, 1, 0); step(1, 3, 0, 1, 0); step(1, 4, 0, 1, 0);
    expect_result("sum_1_4", 10, 4, 10, 0);
    step(0, 0, 0, 1, 0);

    step(1, -5, 0, 1, 0); step(1, 7, 0, 1, 0); step(1, -100, 0, 1, 0); step(1, 3, 0, 1, 0);
    expect_result("signed", -95, 4, -95, 0);
    step(0, 0, 0, 1, 0);

    step(1, 9, 0, 1, 0); step(1, 9, 0, 1, 0); step(0, 0, 1, 1, 0);
    expect_result("flush_alone", 18, 2, 18, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 1, 1, 0);
    #1 check("flush_empty", longint'(vld_a), 0);

    step(1, 6, 1, 1, 0);
    expect_result("flush_beat", 6, 1, 6, 0);
    step(0, 0, 0, 1, 0);
    step(1, 1, 0, 1, 0); step(1, 1, 0, 1, 0); step(1, 1, 0, 1, 0); step(1, 1, 1, 1, 0);
    expect_result("flush_full", 4, 4, 4, 0);
    step(0, 0, 0, 1, 0);

    step(1, 2, 0, 0, 0); step(1, 2, 0, 0, 0); step(1, 2, 0, 0, 0); step(1, 2, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 50, 0, 0, 0);
    expect_result("held", 8, 4, 8, 0);
    step(1, 50, 0, 1, 0);
    step(1, 1, 0, 1, 0); step(1, 1, 0, 1, 0); step(1, 1, 0, 1, 0); step(1, 1, 0, 1, 0);
    expect_result("after_bubble", 4, 4, 4, 0);
    step(0, 0, 0, 1, 0);

    step(1, 127, 0, 1, 0); step(1, 1, 0, 1, 0); step(1, 0, 0, 1, 0); step(1, 0, 0, 1, 0);
    expect_result("wrap8", 128, 4, -128, 1);
    step(0, 0, 0, 1, 0);
    step(1, 1, 0, 1, 0); step(1, 1, 0, 1, 0); step(1, 1, 0, 1, 0); step(1, 1, 0, 1, 0);
    expect_result("ovf_cleared", 4, 4, 4, 0);
    step(0, 0, 0, 1, 0);

    step(1, 5, 0, 1, 0); step(1, 5, 0, 1, 0); step(0, 0, 0, 1, 1);
    step(1, 3, 0, 1, 0); step(1, 3, 0, 1, 0); step(1, 3, 0, 1, 0); step(1, 3, 0, 1, 0);
    expect_result("after_rst", 12, 4, 12, 0);
    step(0, 0, 0, 1, 0);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0,
           ($urandom_range(0, 1) != 0) ? $urandom : $urandom_range(0, 255),
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 99) == 0);
    end
    step(0, 0, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
